// File: rtl/segre_fetch_unit_if.sv
// Fetch-side bus: i-cache lookup port and decode-facing head port.
// master = fetch unit, slave = cache/decode environment.
interface segre_fetch_unit_if #(
  parameter int ADDR_W    = 32,
  parameter int WORD_SIZE = 32
);
  logic                 ic_rd_o;
  logic [ADDR_W-1:0]    ic_addr_o;
  logic                 ic_hit_i;
  logic [WORD_SIZE-1:0] ic_instr_i;
  logic                 instr_valid_o;
  logic                 instr_ready_i;
  logic [WORD_SIZE-1:0] instr_o;
  logic [ADDR_W-1:0]    pc_o;

  modport master (
    output ic_rd_o,
    output ic_addr_o,
    input  ic_hit_i,
    input  ic_instr_i,
    output instr_valid_o,
    input  instr_ready_i,
    output instr_o,
    output pc_o
  );

  modport slave (
    input  ic_rd_o,
    input  ic_addr_o,
    output ic_hit_i,
    output ic_instr_i,
    input  instr_valid_o,
    output instr_ready_i,
    input  instr_o,
    input  pc_o
  );
endinterface

// File: rtl/segre_fetch_unit.sv
// Fetch unit: PC generation, i-cache lookup and circular fetch queue.
// Optional perf counters enabled by defining SEGRE_FETCH_PERF_EN.
module segre_fetch_unit #(
  parameter int              FQ_DEPTH  = 4,
  parameter int              ADDR_SIZE = 32,
  parameter int              ADDR_W    = ADDR_SIZE,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  segre_fetch_unit_if.master fu,
  input  logic              tkbr_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic              misalign_o,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count_o
`ifdef SEGRE_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched_o,
  output logic [31:0]       perf_miss_cycles_o
`endif
);

  localparam int WORD_SIZE = 32;
  localparam int CNT_W     = $clog2(FQ_DEPTH+1);
  localparam int PTR_W     = $clog2(FQ_DEPTH);
  localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

  logic [ADDR_W-1:0]    fetch_pc;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic [ADDR_W-1:0]    q_pc  [FQ_DEPTH];
  logic [WORD_SIZE-1:0] q_ins [FQ_DEPTH];
  logic                 misalign_q;

  logic full;
  logic rd;
  logic push;
  logic pop;
  logic valid;

  // Lookup is judged on start-of-cycle occupancy, so a pop
  // never frees a slot for a same-cycle push.
  assign full  = (count == CNT_W'(FQ_DEPTH));
  assign rd    = !rst_i && !full && !tkbr_i;
  assign push  = rd && fu.ic_hit_i;
  assign valid = !rst_i && !tkbr_i && (count != '0);
  assign pop   = valid && fu.instr_ready_i;

  assign fu.ic_rd_o       = rd;
  assign fu.ic_addr_o     = fetch_pc;
  assign fu.instr_valid_o = valid;
  assign fu.instr_o       = valid ? q_ins[head] : NOP_INSTR;
  assign fu.pc_o          = valid ? q_pc[head] : '0;
  assign misalign_o       = misalign_q;
  assign fq_count_o       = rst_i ? '0 : count;

  // Fetch PC: boot, redirect (word aligned) or advance on hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= BOOT_ADDR;
    end else if (tkbr_i) begin
      fetch_pc <= {new_pc_i[ADDR_W-1:2], 2'b00};
    end else if (push) begin
      fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  // Queue pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk_i) begin
    if (rst_i || tkbr_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage written at the tail on every hit.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_pc[tail]  <= fetch_pc;
      q_ins[tail] <= fu.ic_instr_i;
    end
  end

  // One-cycle flag for a redirect target that was not word aligned.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else if (tkbr_i) begin
      misalign_q <= |new_pc_i[1:0];
    end else begin
      misalign_q <= 1'b0;
    end
  end

`ifdef SEGRE_FETCH_PERF_EN
  logic [31:0] fetched_q;
  logic [31:0] miss_q;
  logic        miss;

  assign miss               = rd && !fu.ic_hit_i;
  assign perf_fetched_o     = fetched_q;
  assign perf_miss_cycles_o = miss_q;

  // Saturating event counters; survive redirects, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetched_q <= '0;
      miss_q    <= '0;
    end else begin
      if (push && fetched_q != 32'hFFFF_FFFF) fetched_q <= fetched_q + 32'd1;
      if (miss && miss_q != 32'hFFFF_FFFF)    miss_q    <= miss_q + 32'd1;
    end
  end
`endif

endmodule
